// File: rtl/time_counter_gen.sv
// Time-of-day counter: 24-hour BCD core with prescaled seconds, digit loads in set mode,
// and a combinational 12/24-hour display mapping.
module time_counter_gen #(
   parameter int unsigned CLK_PER_SEC = 1,
   parameter bit          DEFAULT_12H = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_mode,
   input  logic       load,
   input  logic [5:0] cursor,
   input  logic [3:0] n_digit,
   input  logic       mode_12h_ovr,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hrs0,
   output logic [3:0] hrs1,
   output logic       pm,
   output logic       sec_pulse,
   output logic       day_wrap,
   output logic       load_err
);

   localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    sec0_q, sec0_d, sec1_q, sec1_d, min0_q, min0_d;
   logic [3:0]    min1_q, min1_d, hrs0_q, hrs0_d, hrs1_q, hrs1_d;
   logic          sec_pulse_q, sec_pulse_d, day_wrap_q, day_wrap_d;
   logic          load_err_q, load_err_d;

   logic          tick;
   logic          c0, c1, c2, c3, wrap;
   logic          load_ok;
   logic [7:0]    hr_bin, hr_disp;
   logic          mode_12h;

   // Next-state: prescaler, carry chain and digit loads
   always_comb begin
      presc_d     = presc_q;
      sec0_d      = sec0_q;
      sec1_d      = sec1_q;
      min0_d      = min0_q;
      min1_d      = min1_q;
      hrs0_d      = hrs0_q;
      hrs1_d      = hrs1_q;
      sec_pulse_d = 1'b0;
      day_wrap_d  = 1'b0;
      load_err_d  = 1'b0;
      tick        = 1'b0;
      load_ok     = 1'b0;

      c0   = (sec0_q == 4'd9);
      c1   = c0 && (sec1_q == 4'd5);
      c2   = c1 && (min0_q == 4'd9);
      c3   = c2 && (min1_q == 4'd5);
      wrap = c3 && (hrs1_q == 4'd2) && (hrs0_q == 4'd3);

      if (set_mode) begin
         presc_d = '0;
         if (load) begin
            // Non-one-hot cursors fall into default and are rejected
            unique case (cursor)
               6'b000001: load_ok = (n_digit <= 4'd9);
               6'b000010: load_ok = (n_digit <= 4'd5);
               6'b000100: load_ok = (n_digit <= 4'd9);
               6'b001000: load_ok = (n_digit <= 4'd5);
               6'b010000: load_ok = (n_digit <= 4'd9) &&
                                    (8'(hrs1_q) * 8'd10 + 8'(n_digit) <= 8'd23);
               6'b100000: load_ok = (n_digit <= 4'd2) &&
                                    (8'(n_digit) * 8'd10 + 8'(hrs0_q) <= 8'd23);
               default:   load_ok = 1'b0;
            endcase
            if (load_ok) begin
               if (cursor[0]) sec0_d = n_digit;
               if (cursor[1]) sec1_d = n_digit;
               if (cursor[2]) min0_d = n_digit;
               if (cursor[3]) min1_d = n_digit;
               if (cursor[4]) hrs0_d = n_digit;
               if (cursor[5]) hrs1_d = n_digit;
            end else begin
               load_err_d = 1'b1;
            end
         end
      end else begin
         load_err_d = load;
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      if (tick) begin
         sec_pulse_d = 1'b1;
         sec0_d = c0 ? 4'd0 : sec0_q + 4'd1;
         if (c0) sec1_d = (sec1_q == 4'd5) ? 4'd0 : sec1_q + 4'd1;
         if (c1) min0_d = (min0_q == 4'd9) ? 4'd0 : min0_q + 4'd1;
         if (c2) min1_d = (min1_q == 4'd5) ? 4'd0 : min1_q + 4'd1;
         if (wrap) begin
            hrs0_d     = 4'd0;
            hrs1_d     = 4'd0;
            day_wrap_d = 1'b1;
         end else if (c3) begin
            hrs0_d = (hrs0_q == 4'd9) ? 4'd0 : hrs0_q + 4'd1;
            if (hrs0_q == 4'd9) hrs1_d = hrs1_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         sec0_q      <= 4'd0;
         sec1_q      <= 4'd0;
         min0_q      <= 4'd0;
         min1_q      <= 4'd0;
         hrs0_q      <= 4'd0;
         hrs1_q      <= 4'd0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         sec0_q      <= sec0_d;
         sec1_q      <= sec1_d;
         min0_q      <= min0_d;
         min1_q      <= min1_d;
         hrs0_q      <= hrs0_d;
         hrs1_q      <= hrs1_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
         load_err_q  <= load_err_d;
      end
   end

   // Display mapping: hour 0 and 12 show as 12, 13..23 fold down by 12
   always_comb begin
      mode_12h = mode_12h_ovr | DEFAULT_12H;
      hr_bin   = 8'(hrs1_q) * 8'd10 + 8'(hrs0_q);
      pm       = (hr_bin >= 8'd12);
      if (hr_bin == 8'd0)       hr_disp = 8'd12;
      else if (hr_bin > 8'd12)  hr_disp = hr_bin - 8'd12;
      else                      hr_disp = hr_bin;
      if (mode_12h) begin
         hrs1 = (hr_disp >= 8'd10) ? 4'd1 : 4'd0;
         hrs0 = (hr_disp >= 8'd10) ? 4'(hr_disp - 8'd10) : 4'(hr_disp);
      end else begin
         hrs1 = hrs1_q;
         hrs0 = hrs0_q;
      end
   end

   assign sec0      = sec0_q;
   assign sec1      = sec1_q;
   assign min0      = min0_q;
   assign min1      = min1_q;
   assign sec_pulse = sec_pulse_q;
   assign day_wrap  = day_wrap_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_counter_gen.sv
// Bench for time_counter_gen: two instances (1 and 4 clocks per second) checked against a
// seconds-of-day reference model, plus a directed vector table and corner sequences.
module tb_time_counter_gen;

   logic       clk = 1'b0;
   logic       rst, set_mode, load, mode_12h_ovr;
   logic [5:0] cursor;
   logic [3:0] n_digit;

   logic [3:0] a_s0, a_s1, a_m0, a_m1, a_h0, a_h1;
   logic [3:0] b_s0, b_s1, b_m0, b_m1, b_h0, b_h1;
   logic       a_pm, a_sp, a_dw, a_le, b_pm, b_sp, b_dw, b_le;

   always #5 clk = ~clk;

   time_counter_gen #(.CLK_PER_SEC(1), .DEFAULT_12H(1'b0)) dut_a (
      .clk(clk), .rst(rst), .set_mode(set_mode), .load(load), .cursor(cursor),
      .n_digit(n_digit), .mode_12h_ovr(mode_12h_ovr),
      .sec0(a_s0), .sec1(a_s1), .min0(a_m0), .min1(a_m1), .hrs0(a_h0), .hrs1(a_h1),
      .pm(a_pm), .sec_pulse(a_sp), .day_wrap(a_dw), .load_err(a_le));

   time_counter_gen #(.CLK_PER_SEC(4), .DEFAULT_12H(1'b0)) dut_b (
      .clk(clk), .rst(rst), .set_mode(set_mode), .load(load), .cursor(cursor),
      .n_digit(n_digit), .mode_12h_ovr(mode_12h_ovr),
      .sec0(b_s0), .sec1(b_s1), .min0(b_m0), .min1(b_m1), .hrs0(b_h0), .hrs1(b_h1),
      .pm(b_pm), .sec_pulse(b_sp), .day_wrap(b_dw), .load_err(b_le));

   logic [27:0] got [2];
   assign got[0] = {a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, a_pm, a_sp, a_dw, a_le};
   assign got[1] = {b_h1, b_h0, b_m1, b_m0, b_s1, b_s0, b_pm, b_sp, b_dw, b_le};

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: time as seconds of day, prescaler as a plain count
   int unsigned cps [2] = '{1, 4};
   int unsigned mt [2];
   int unsigned mp [2];
   bit msp [2], mdw [2], mle [2];

   function automatic bit try_load(input int unsigned t, input logic [5:0] c,
                                   input logic [3:0] n, output int unsigned nt);
      int unsigned d [6];
      int unsigned h, m, s;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      d[0] = s % 10; d[1] = s / 10; d[2] = m % 10; d[3] = m / 10; d[4] = h % 10; d[5] = h / 10;
      nt = t;
      if ($countones(c) != 1) return 1'b0;
      for (int k = 0; k < 6; k++) if (c[k]) d[k] = int'(n);
      if (d[0] > 9 || d[1] > 5 || d[2] > 9 || d[3] > 5 || d[4] > 9 || d[5] > 2) return 1'b0;
      if (d[5] * 10 + d[4] > 23) return 1'b0;
      nt = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
      return 1'b1;
   endfunction

   function automatic logic [27:0] expect_vec(input int unsigned t, input bit sp, input bit dw,
                                              input bit le, input bit ovr);
      int unsigned h, m, s, dh;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      dh = ovr ? ((h % 12 == 0) ? 12 : h % 12) : h;
      return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              (h >= 12), sp, dw, le};
   endfunction

   task automatic model_step();
      int unsigned nt;
      for (int i = 0; i < 2; i++) begin
         msp[i] = 1'b0; mdw[i] = 1'b0; mle[i] = 1'b0;
         if (rst) begin
            mt[i] = 0; mp[i] = 0;
         end else if (set_mode) begin
            mp[i] = 0;
            if (load) begin
               if (try_load(mt[i], cursor, n_digit, nt)) mt[i] = nt;
               else mle[i] = 1'b1;
            end
         end else begin
            if (load) mle[i] = 1'b1;
            if (mp[i] == cps[i] - 1) begin
               mp[i] = 0;
               mt[i] = (mt[i] + 1) % 86400;
               msp[i] = 1'b1;
               mdw[i] = (mt[i] == 0);
            end else begin
               mp[i]++;
            end
         end
      end
   endtask

   task automatic check_model();
      logic [27:0] exp_v;
      for (int i = 0; i < 2; i++) begin
         exp_v = expect_vec(mt[i], msp[i], mdw[i], mle[i], mode_12h_ovr);
         n_cmp++;
         if (got[i] !== exp_v) begin
            n_fail++;
            $display("FAIL model_%0d t=%0t got=%h expected=%h", i, $time, got[i], exp_v);
         end
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit l, input logic [5:0] c,
                      input logic [3:0] n, input bit o);
      rst = r; set_mode = s; load = l; cursor = c; n_digit = n; mode_12h_ovr = o;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   typedef struct {
      bit          r, s, l, o;
      logic [5:0]  c;
      logic [3:0]  n;
      logic [27:0] exp_v;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit s, input bit l, input logic [5:0] c,
                               input logic [3:0] n, input bit o, input logic [23:0] t,
                               input bit p, input bit sp, input bit dw, input bit le);
      vec_t v;
      v.r = r; v.s = s; v.l = l; v.c = c; v.n = n; v.o = o;
      v.exp_v = {t, p, sp, dw, le};
      return v;
   endfunction

   vec_t tbl [31];

   initial begin
      // Directed vectors, expected values for the 1-clock-per-second instance
      tbl[0]  = mk(1, 0, 0, 6'b000000, 4'd0,  0, 24'h000000, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 1, 6'b100000, 4'd2,  0, 24'h200000, 1, 0, 0, 0);
      tbl[2]  = mk(0, 1, 1, 6'b010000, 4'd3,  0, 24'h230000, 1, 0, 0, 0);
      tbl[3]  = mk(0, 1, 1, 6'b001000, 4'd5,  0, 24'h235000, 1, 0, 0, 0);
      tbl[4]  = mk(0, 1, 1, 6'b000100, 4'd9,  0, 24'h235900, 1, 0, 0, 0);
      tbl[5]  = mk(0, 1, 1, 6'b000010, 4'd5,  0, 24'h235950, 1, 0, 0, 0);
      tbl[6]  = mk(0, 1, 1, 6'b000001, 4'd8,  0, 24'h235958, 1, 0, 0, 0);
      tbl[7]  = mk(0, 1, 1, 6'b000011, 4'd1,  0, 24'h235958, 1, 0, 0, 1);
      tbl[8]  = mk(0, 1, 1, 6'b000001, 4'd10, 0, 24'h235958, 1, 0, 0, 1);
      tbl[9]  = mk(0, 0, 0, 6'b000000, 4'd0,  0, 24'h235959, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 0, 6'b000000, 4'd0,  0, 24'h000000, 0, 1, 1, 0);
      tbl[11] = mk(0, 0, 0, 6'b000000, 4'd0,  0, 24'h000001, 0, 1, 0, 0);
      tbl[12] = mk(0, 1, 0, 6'b000000, 4'd0,  0, 24'h000001, 0, 0, 0, 0);
      tbl[13] = mk(0, 1, 0, 6'b000000, 4'd0,  1, 24'h120001, 0, 0, 0, 0);
      tbl[14] = mk(0, 1, 1, 6'b100000, 4'd1,  1, 24'h100001, 0, 0, 0, 0);
      tbl[15] = mk(0, 1, 1, 6'b010000, 4'd3,  1, 24'h010001, 1, 0, 0, 0);
      tbl[16] = mk(0, 1, 1, 6'b000100, 4'd5,  1, 24'h010501, 1, 0, 0, 0);
      tbl[17] = mk(0, 1, 1, 6'b000001, 4'd0,  1, 24'h010500, 1, 0, 0, 0);
      tbl[18] = mk(0, 1, 1, 6'b010000, 4'd2,  1, 24'h120500, 1, 0, 0, 0);
      tbl[19] = mk(0, 1, 1, 6'b010000, 4'd5,  0, 24'h150500, 1, 0, 0, 0);
      tbl[20] = mk(0, 1, 1, 6'b100000, 4'd2,  0, 24'h150500, 1, 0, 0, 1);
      tbl[21] = mk(0, 0, 1, 6'b000001, 4'd3,  0, 24'h150501, 1, 1, 0, 1);
      tbl[22] = mk(1, 1, 1, 6'b010000, 4'd1,  0, 24'h000000, 0, 0, 0, 0);
      tbl[23] = mk(0, 1, 1, 6'b010000, 4'd9,  0, 24'h090000, 0, 0, 0, 0);
      tbl[24] = mk(0, 1, 1, 6'b001000, 4'd5,  0, 24'h095000, 0, 0, 0, 0);
      tbl[25] = mk(0, 1, 1, 6'b000100, 4'd9,  0, 24'h095900, 0, 0, 0, 0);
      tbl[26] = mk(0, 1, 1, 6'b000010, 4'd5,  0, 24'h095950, 0, 0, 0, 0);
      tbl[27] = mk(0, 1, 1, 6'b000001, 4'd9,  0, 24'h095959, 0, 0, 0, 0);
      tbl[28] = mk(1, 0, 0, 6'b000000, 4'd0,  0, 24'h000000, 0, 0, 0, 0);
      tbl[29] = mk(0, 0, 0, 6'b000000, 4'd0,  0, 24'h000001, 0, 1, 0, 0);
      tbl[30] = mk(0, 1, 1, 6'b000000, 4'd1,  0, 24'h000001, 0, 0, 0, 1);

      rst = 1'b1; set_mode = 1'b0; load = 1'b0; cursor = '0; n_digit = '0; mode_12h_ovr = 1'b0;
      for (int i = 0; i < 31; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].c, tbl[i].n, tbl[i].o);
         n_cmp++;
         if (got[0] !== tbl[i].exp_v) begin
            n_fail++;
            $display("FAIL vec_%0d got=%h expected=%h", i, got[0], tbl[i].exp_v);
         end
      end

      // Four clocks per second from reset: sec0 steps at cycles 4, 8, 12, 16
      cyc(1, 0, 0, 6'b0, 4'd0, 0);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 0, 0, 6'b0, 4'd0, 0);
         n_cmp++;
         if ({b_s0, b_sp} !== {4'(k / 4), (k % 4 == 0)}) begin
            n_fail++;
            $display("FAIL presc4_cycle%0d got sec0=%0d sp=%0b expected sec0=%0d sp=%0b",
                     k, b_s0, b_sp, k / 4, (k % 4 == 0));
         end
      end

      // Display mode toggling every cycle while counting must not disturb time
      cyc(0, 1, 1, 6'b100000, 4'd1, 0);
      cyc(0, 1, 1, 6'b010000, 4'd1, 0);
      cyc(0, 1, 1, 6'b001000, 4'd5, 0);
      cyc(0, 1, 1, 6'b000100, 4'd9, 0);
      for (int k = 0; k < 80; k++) cyc(0, 0, 0, 6'b0, 4'd0, k[0]);

      // Randomized traffic against the model
      begin
         bit sm = 1'b0;
         logic [5:0] c;
         for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 15) == 0) sm = ~sm;
            if ($urandom_range(0, 3) != 0) c = 6'(1 << $urandom_range(0, 5));
            else c = 6'($urandom);
            cyc(($urandom_range(0, 199) == 0), sm, ($urandom_range(0, 3) == 0), c,
                4'($urandom_range(0, 15)), 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/time_counter_gen.md
TIME_COUNTER_GEN -- requirements
Module: time_counter_gen

Interface
REQ-001 The block SHALL have a parameter CLK_PER_SEC, default 1, giving the number of clk cycles per seconds increment (legal range 1..2^24).
REQ-002 The block SHALL have a parameter DEFAULT_12H, default 0, giving the display mode selected when mode_12h_ovr is low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 set_mode  input  1  high: counting frozen, digit loads allowed.
REQ-006 load  input  1  one-cycle strobe that writes n_digit into the digit selected by cursor.
REQ-007 cursor  input  6  one-hot digit select: bit0 sec0, bit1 sec1, bit2 min0, bit3 min1, bit4 hrs0, bit5 hrs1.
REQ-008 n_digit  input  4  BCD value to load.
REQ-009 mode_12h_ovr  input  1  high: 12-hour display regardless of DEFAULT_12H.
REQ-010 sec0,sec1,min0,min1,hrs0,hrs1  output  4 each  displayed BCD digits.
REQ-011 pm  output  1  high when the internal hour is 12..23.
REQ-012 sec_pulse  output  1  one-cycle pulse coincident with each seconds increment.
REQ-013 day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.
REQ-014 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-015 Time SHALL be held internally as 24-hour BCD (H1 H0 : M1 M0 : S1 S0), range 00:00:00..23:59:59.
REQ-016 The prescaler SHALL count 0..CLK_PER_SEC-1 while set_mode is low; the seconds increment occurs in the cycle it reaches CLK_PER_SEC-1, after which it returns to 0.
REQ-017 With CLK_PER_SEC=1, time SHALL increment every cycle that set_mode is low.
REQ-018 Carry chain per increment: S0 9->0 carries to S1; S1 5->0 carries to M0; M0 9->0 carries to M1; M1 5->0 carries to H0; H0 9->0 carries to H1; H1H0 23->00 instead of 24.
REQ-019 All digit updates belonging to one increment SHALL occur in the same clock edge, with no intermediate values visible.
REQ-020 sec_pulse and day_wrap SHALL be registered and asserted in the same cycle that the new digit values first appear.
REQ-021 While set_mode is high, the prescaler SHALL be held at 0, time SHALL not advance, and sec_pulse and day_wrap SHALL be 0.
REQ-022 After set_mode falls, the first increment SHALL appear CLK_PER_SEC cycles later.
REQ-023 A load (set_mode=1, load=1) SHALL write n_digit into the selected internal digit in one cycle, provided the result is valid.
REQ-024 Valid limits: S0<=9, S1<=5, M0<=9, M1<=5, H0<=9, H1<=2, and H1H0<=23 after the write.
REQ-025 A load with an invalid value, a cursor that is not one-hot (zero bits or several bits), or load=1 while set_mode=0 SHALL change no state and SHALL pulse load_err in the next cycle.
REQ-026 Hour loads SHALL always be interpreted in 24-hour coordinates, independent of the display mode.
REQ-027 In 24-hour display, the outputs SHALL equal the internal digits.
REQ-028 In 12-hour display, the displayed hour SHALL be: 12 for internal 00 and 12; internal H-12 for internal 13..23; internal H otherwise. The display mapping SHALL be combinational from the registers, with no added latency.
REQ-029 pm SHALL be valid in both display modes.
REQ-030 A change of display mode SHALL take effect on the outputs immediately and SHALL not alter the internal time or the prescaler.

Reset
REQ-031 With rst high at a clock edge, all digits SHALL be 0, the prescaler 0, and pm, sec_pulse, day_wrap and load_err 0.
REQ-032 Reset SHALL take priority over load, set_mode and counting, including mid-increment.
REQ-033 The first increment after rst falls SHALL appear CLK_PER_SEC cycles later.

Verification
REQ-034 CLK_PER_SEC=4, reset, then free-run 16 cycles -> sec0 steps 1,2,3,4 at cycles 4,8,12,16, with sec_pulse high on exactly those cycles.
REQ-035 Load 23:59:58, release set_mode, CLK_PER_SEC=1 -> 23:59:59, then 00:00:00 with day_wrap=1 for one cycle and pm 1->0.
REQ-036 In 12-hour mode, internal 00:00:00 -> display 12:00:00 with pm=0; internal 13:05:00 -> display 01:05:00 with pm=1; internal 12:00:00 -> display 12 with pm=1.
REQ-037 With hrs0=5, load hrs1=2 -> rejected, load_err pulses, time unchanged; load with cursor 6'b000011 -> rejected.
REQ-038 Assert rst during an active load, and separately in the cycle of a carry from 09:59:59 -> all outputs 0 on the next edge, with no pulses.
REQ-039 Toggle mode_12h_ovr every cycle while counting -> internal time sequence identical to a run without toggling.
